// File: rtl/psr_unit_if.sv
// psr_unit_if: signal bundle between the core and the processor status register.
//   master : core side (decoder, ALU, stack logic, SO pin) - drives requests and data
//   slave  : psr_unit - drives P, the push image, the update acknowledge and shadow status
// Signals:
//   db_in/db_load, id_in/id_load     : P loads from the data bus and the decoder path
//   irq_entry                        : interrupt/BRK entry (set I, clear D)
//   flag_op_valid/flag_op            : CLC/SEC/CLI/SEI/CLD/SED/CLV opcodes
//   upd_req/upd_mask/*_res/upd_ack   : masked ALU flag update with 4-phase handshake
//   so_n                             : asynchronous Set-Overflow pin, active low
//   hw_push/db_out                   : stack push image of P (B bit from hw_push)
//   p_out, c_carry, d_decimal, i_mask: current P and frequently used flags
//   shadow_push/pop/cnt/err          : optional shadow stack (PSR_SHADOW_STACK_EN)
interface psr_unit_if;
    logic [7:0] db_in;
    logic       db_load;
    logic [7:0] id_in;
    logic       id_load;
    logic       irq_entry;
    logic       flag_op_valid;
    logic [2:0] flag_op;
    logic       upd_req;
    logic [3:0] upd_mask;
    logic       n_res;
    logic       v_res;
    logic       z_res;
    logic       c_res;
    logic       upd_ack;
    logic       so_n;
    logic       hw_push;
    logic [7:0] p_out;
    logic [7:0] db_out;
    logic       c_carry;
    logic       d_decimal;
    logic       i_mask;
    logic       shadow_push;
    logic       shadow_pop;
    logic [4:0] shadow_cnt;
    logic       shadow_err;

    modport master (
        output db_in, db_load, id_in, id_load, irq_entry, flag_op_valid, flag_op,
               upd_req, upd_mask, n_res, v_res, z_res, c_res, so_n, hw_push,
               shadow_push, shadow_pop,
        input  upd_ack, p_out, db_out, c_carry, d_decimal, i_mask, shadow_cnt, shadow_err
    );

    modport slave (
        input  db_in, db_load, id_in, id_load, irq_entry, flag_op_valid, flag_op,
               upd_req, upd_mask, n_res, v_res, z_res, c_res, so_n, hw_push,
               shadow_push, shadow_pop,
        output upd_ack, p_out, db_out, c_carry, d_decimal, i_mask, shadow_cnt, shadow_err
    );
endinterface

// File: rtl/psr_unit.sv
// psr_unit: 65C02 processor status register P, layout {N,V,1,B,D,I,Z,C}.
// One source writes P per cycle, priority:
//   reset > shadow_pop > db_load > id_load > irq_entry > ALU update > flag_op
// then a synchronised falling edge on so_n forces V = 1 on top of that.
// Ports:
//   phi2  : core clock, all state on the rising edge
//   reset : synchronous, active high
//   bus   : psr_unit_if.slave (loads, flag ops, ALU update handshake, SO pin,
//           push image, P outputs, shadow stack controls/status)
// Parameters: RESET_P (P after reset), SO_SYNC (2..4 synchroniser flops on so_n),
//   SHADOW_DEPTH (1..16 shadow entries).
// Optional feature macro PSR_SHADOW_STACK_EN: LIFO of P values for fast interrupt
// context save/restore. Without it shadow_push/shadow_pop are ignored and
// shadow_cnt/shadow_err read 0.
module psr_unit #(
    parameter logic [7:0] RESET_P      = 8'h34,
    parameter int         SO_SYNC      = 2,
    parameter int         SHADOW_DEPTH = 4
) (
    input logic     phi2,
    input logic     reset,
    psr_unit_if.slave bus
);
    localparam int BIT_C = 0;
    localparam int BIT_Z = 1;
    localparam int BIT_I = 2;
    localparam int BIT_D = 3;
    localparam int BIT_V = 6;
    localparam int BIT_N = 7;

    logic [7:0]         p_q;
    logic [7:0]         p_d;
    logic               upd_ack_q;
    logic               acc_latch_q;
    logic [SO_SYNC-1:0] so_sync_q;
    logic               so_prev_q;
    logic               so_fall;
    logic               pop_eff;
    logic [7:0]         pop_val;
    logic               higher;
    logic               accept;

`ifdef PSR_SHADOW_STACK_EN
    localparam int AW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

    logic [7:0] stk_q [2**AW];
    logic [4:0] cnt_q;
    logic       err_q;
    logic [4:0] top;
    logic       full;
    logic       empty;
    logic       exchange;

    assign top      = cnt_q - 5'd1;
    assign full     = (cnt_q == 5'(SHADOW_DEPTH));
    assign empty    = (cnt_q == 5'd0);
    // push+pop on an empty stack degenerates to a plain push
    assign exchange = bus.shadow_push & bus.shadow_pop & ~empty;
    assign pop_eff  = bus.shadow_pop & ~empty;
    assign pop_val  = stk_q[top[AW-1:0]];

    always_ff @(posedge phi2) begin
        if (reset) begin
            cnt_q <= 5'd0;
            err_q <= 1'b0;
        end else if (exchange) begin
            cnt_q <= cnt_q;
        end else if (bus.shadow_push) begin
            if (full) err_q <= 1'b1;
            else      cnt_q <= cnt_q + 5'd1;
        end else if (bus.shadow_pop) begin
            if (empty) err_q <= 1'b1;
            else       cnt_q <= cnt_q - 5'd1;
        end
    end

    // stack contents need no reset; cnt_q alone defines what is valid
    always_ff @(posedge phi2) begin
        if (!reset) begin
            if (exchange)
                stk_q[top[AW-1:0]] <= p_q;
            else if (bus.shadow_push && !full)
                stk_q[cnt_q[AW-1:0]] <= p_q;
        end
    end

    assign bus.shadow_cnt = cnt_q;
    assign bus.shadow_err = err_q;
`else
    logic shadow_unused;

    assign shadow_unused  = bus.shadow_push ^ bus.shadow_pop;
    assign pop_eff        = 1'b0;
    assign pop_val        = RESET_P;
    assign bus.shadow_cnt = 5'd0;
    assign bus.shadow_err = 1'b0;
`endif

    // SO: synchroniser chain followed by a previous-value flop for edge detect
    assign so_fall = so_prev_q & ~so_sync_q[SO_SYNC-1];

    always_ff @(posedge phi2) begin
        if (reset) begin
            so_sync_q <= '1;
            so_prev_q <= 1'b1;
        end else begin
            so_sync_q <= {so_sync_q[SO_SYNC-2:0], bus.so_n};
            so_prev_q <= so_sync_q[SO_SYNC-1];
        end
    end

    // ALU update: accepted once per request; the latch holds off re-acceptance
    // until upd_req drops, blocked requests simply stay pending
    assign higher = pop_eff | bus.db_load | bus.id_load | bus.irq_entry;
    assign accept = bus.upd_req & ~higher & ~acc_latch_q;

    always_ff @(posedge phi2) begin
        if (reset) begin
            upd_ack_q   <= 1'b0;
            acc_latch_q <= 1'b0;
        end else begin
            upd_ack_q <= accept;
            if (!bus.upd_req)
                acc_latch_q <= 1'b0;
            else if (accept)
                acc_latch_q <= 1'b1;
        end
    end

    always_comb begin
        p_d = p_q;
        if (pop_eff) begin
            p_d = pop_val;
        end else if (bus.db_load) begin
            p_d = bus.db_in;
        end else if (bus.id_load) begin
            p_d = bus.id_in;
        end else if (bus.irq_entry) begin
            p_d[BIT_I] = 1'b1;
            p_d[BIT_D] = 1'b0;
        end else if (accept) begin
            if (bus.upd_mask[3]) p_d[BIT_N] = bus.n_res;
            if (bus.upd_mask[2]) p_d[BIT_V] = bus.v_res;
            if (bus.upd_mask[1]) p_d[BIT_Z] = bus.z_res;
            if (bus.upd_mask[0]) p_d[BIT_C] = bus.c_res;
        end else if (bus.flag_op_valid) begin
            case (bus.flag_op)
                3'd0:    p_d[BIT_C] = 1'b0;
                3'd1:    p_d[BIT_C] = 1'b1;
                3'd2:    p_d[BIT_I] = 1'b0;
                3'd3:    p_d[BIT_I] = 1'b1;
                3'd4:    p_d[BIT_D] = 1'b0;
                3'd5:    p_d[BIT_D] = 1'b1;
                3'd6:    p_d[BIT_V] = 1'b0;
                default: p_d = p_q;
            endcase
        end
        if (so_fall)
            p_d[BIT_V] = 1'b1;
        p_d[5:4] = 2'b11;
    end

    always_ff @(posedge phi2) begin
        if (reset) p_q <= RESET_P | 8'h30;
        else       p_q <= p_d;
    end

    assign bus.p_out     = {p_q[7:6], 2'b11, p_q[3:0]};
    assign bus.db_out    = {p_q[7:6], 1'b1, ~bus.hw_push, p_q[3:0]};
    assign bus.c_carry   = p_q[BIT_C];
    assign bus.d_decimal = p_q[BIT_D];
    assign bus.i_mask    = p_q[BIT_I];
    assign bus.upd_ack   = upd_ack_q;
endmodule

// File: tb/tb_psr_unit.sv
// Scoreboard bench for psr_unit: the stimulus process pushes expected values
// (tagged with the cycle they must be observed in) and expected ack cycles;
// a monitor on the falling edge pops and compares.
module tb_psr_unit;
    logic phi2  = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    psr_unit_if bus();

    psr_unit dut (
        .phi2  (phi2),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 phi2 = ~phi2;
    always @(posedge phi2) cyc++;

    localparam int S_P   = 0;
    localparam int S_DB  = 1;
    localparam int S_ACK = 2;
    localparam int S_CNT = 3;
    localparam int S_ERR = 4;
    localparam int S_I   = 5;
    localparam int S_D   = 6;
    localparam int S_C   = 7;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] act(int sel);
        case (sel)
            S_P:     return bus.p_out;
            S_DB:    return bus.db_out;
            S_ACK:   return {7'd0, bus.upd_ack};
            S_CNT:   return {3'd0, bus.shadow_cnt};
            S_ERR:   return {7'd0, bus.shadow_err};
            S_I:     return {7'd0, bus.i_mask};
            S_D:     return {7'd0, bus.d_decimal};
            default: return {7'd0, bus.c_carry};
        endcase
    endfunction

    task automatic exp_push(string name, int sel, logic [7:0] val, int dly);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // next cycle, inputs change 1 time unit after the rising edge; pulses clear
    task automatic step();
        @(posedge phi2);
        #1;
        bus.db_load       = 1'b0;
        bus.id_load       = 1'b0;
        bus.irq_entry     = 1'b0;
        bus.flag_op_valid = 1'b0;
        bus.shadow_push   = 1'b0;
        bus.shadow_pop    = 1'b0;
    endtask

    exp_t       mon_e;
    logic [7:0] mon_a;
    int         mon_c;

    always @(negedge phi2) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_a = act(mon_e.sel);
            n_checks++;
            if (mon_e.cyc != cyc || mon_a !== mon_e.val) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %h, expected %h (due cyc %0d)",
                         mon_e.name, cyc, mon_a, mon_e.val, mon_e.cyc);
            end
        end
        if (bus.upd_ack === 1'b1) begin
            n_checks++;
            if (ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack @cyc %0d: got ack, expected none", cyc);
            end else begin
                mon_c = ack_q.pop_front();
                if (mon_c != cyc) begin
                    n_fail++;
                    $display("FAIL ack_cycle: got ack at cyc %0d, expected cyc %0d", cyc, mon_c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] p;
    } fop_t;

    fop_t fops[8] = '{
        '{3'd1, 8'h35}, '{3'd5, 8'h3D}, '{3'd2, 8'h39}, '{3'd0, 8'h38},
        '{3'd3, 8'h3C}, '{3'd4, 8'h34}, '{3'd7, 8'h34}, '{3'd6, 8'h34}
    };

    initial begin
        bus.db_in = 8'h00;  bus.db_load = 1'b0;
        bus.id_in = 8'h00;  bus.id_load = 1'b0;
        bus.irq_entry = 1'b0;
        bus.flag_op_valid = 1'b0; bus.flag_op = 3'd7;
        bus.upd_req = 1'b0; bus.upd_mask = 4'b0000;
        bus.n_res = 1'b0; bus.v_res = 1'b0; bus.z_res = 1'b0; bus.c_res = 1'b0;
        bus.so_n = 1'b1; bus.hw_push = 1'b0;
        bus.shadow_push = 1'b0; bus.shadow_pop = 1'b0;

        // reset
        step();
        reset = 1'b0;
        exp_push("reset_p", S_P, 8'h34, 0);
        exp_push("reset_ack", S_ACK, 8'h00, 0);
        exp_push("reset_i", S_I, 8'h01, 0);
        exp_push("reset_d", S_D, 8'h00, 0);
        exp_push("reset_c", S_C, 8'h00, 0);
        exp_push("reset_cnt", S_CNT, 8'h00, 0);
        exp_push("reset_err", S_ERR, 8'h00, 0);

        // masked update, request held high afterwards
        step();
        bus.db_load = 1'b1; bus.db_in = 8'h30;
        exp_push("load_30", S_P, 8'h30, 1);
        step();
        bus.upd_req = 1'b1; bus.upd_mask = 4'b1001;
        bus.n_res = 1'b1; bus.v_res = 1'b1; bus.z_res = 1'b1; bus.c_res = 1'b1;
        exp_push("upd_1001", S_P, 8'hB1, 1);
        exp_push("upd_ack_hi", S_ACK, 8'h01, 1);
        ack_q.push_back(cyc + 1);
        for (int i = 0; i < 5; i++) begin
            step();
            exp_push("upd_held_noack", S_ACK, 8'h00, 1);
            exp_push("upd_held_p", S_P, 8'hB1, 1);
        end
        step();
        bus.upd_req = 1'b0;

        // db_load vs ALU update vs SEC in one cycle
        step();
        bus.db_load = 1'b1; bus.db_in = 8'h00;
        bus.upd_req = 1'b1; bus.upd_mask = 4'b1111;
        bus.n_res = 1'b1; bus.v_res = 1'b0; bus.z_res = 1'b1; bus.c_res = 1'b0;
        bus.flag_op_valid = 1'b1; bus.flag_op = 3'd1;
        exp_push("prio_db", S_P, 8'h30, 1);
        exp_push("prio_noack", S_ACK, 8'h00, 1);
        step();
        exp_push("pending_upd", S_P, 8'hB2, 1);
        exp_push("pending_ack", S_ACK, 8'h01, 1);
        ack_q.push_back(cyc + 1);
        step();
        bus.upd_req = 1'b0;
        exp_push("pending_ack_lo", S_ACK, 8'h00, 1);

        // id_load beats irq_entry; push images and interrupt entry
        step();
        bus.id_load = 1'b1; bus.id_in = 8'h38; bus.irq_entry = 1'b1;
        exp_push("id_over_irq", S_P, 8'h38, 1);
        step();
        bus.hw_push = 1'b1; bus.irq_entry = 1'b1;
        exp_push("db_out_hw", S_DB, 8'h28, 0);
        exp_push("irq_entry", S_P, 8'h34, 1);
        step();
        bus.hw_push = 1'b0;
        exp_push("db_out_brk", S_DB, 8'h34, 0);
        exp_push("irq_i", S_I, 8'h01, 0);
        exp_push("irq_d", S_D, 8'h00, 0);

        // flag opcodes
        foreach (fops[i]) begin
            step();
            bus.flag_op_valid = 1'b1; bus.flag_op = fops[i].op;
            exp_push("flag_op", S_P, fops[i].p, 1);
            if (fops[i].op == 3'd1) exp_push("sec_c", S_C, 8'h01, 1);
        end
        step();
        bus.flag_op = 3'd1;
        exp_push("flag_op_invalid", S_P, 8'h34, 1);

        // flag_op blocked by irq_entry is dropped
        step();
        bus.irq_entry = 1'b1; bus.flag_op_valid = 1'b1; bus.flag_op = 3'd5;
        exp_push("blocked_sed", S_P, 8'h34, 1);
        step();
        exp_push("sed_not_queued", S_P, 8'h34, 1);

        // V-only update then CLV
        step();
        bus.upd_req = 1'b1; bus.upd_mask = 4'b0100;
        bus.n_res = 1'b1; bus.v_res = 1'b1; bus.z_res = 1'b1; bus.c_res = 1'b1;
        exp_push("upd_v_only", S_P, 8'h74, 1);
        ack_q.push_back(cyc + 1);
        step();
        bus.upd_req = 1'b0;
        step();
        bus.flag_op_valid = 1'b1; bus.flag_op = 3'd6;
        exp_push("clv", S_P, 8'h34, 1);

        // SO: falling edge sets V on the 2nd edge after the first low sample
        step();
        bus.so_n = 1'b0;
        exp_push("so_wait1", S_P, 8'h34, 1);
        exp_push("so_wait2", S_P, 8'h34, 2);
        step();
        step();
        bus.flag_op_valid = 1'b1; bus.flag_op = 3'd6;
        exp_push("so_beats_clv", S_P, 8'h74, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            exp_push("so_held", S_P, 8'h74, 1);
        end
        step();
        bus.flag_op_valid = 1'b1; bus.flag_op = 3'd6;
        exp_push("clv_after_so", S_P, 8'h34, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_push("so_once", S_P, 8'h34, 1);
        end
        step();
        bus.so_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_push("so_rise_ignored", S_P, 8'h34, 1);
        end

`ifdef PSR_SHADOW_STACK_EN
        step();
        bus.db_load = 1'b1; bus.db_in = 8'h31;
        step();
        bus.shadow_push = 1'b1; bus.db_load = 1'b1; bus.db_in = 8'h32;
        step();
        bus.shadow_push = 1'b1; bus.db_load = 1'b1; bus.db_in = 8'h33;
        step();
        bus.shadow_push = 1'b1; bus.db_load = 1'b1; bus.db_in = 8'h3C;
        step();
        bus.shadow_push = 1'b1; bus.db_load = 1'b1; bus.db_in = 8'hF0;
        exp_push("sh_cnt4", S_CNT, 8'h04, 1);
        exp_push("sh_err0", S_ERR, 8'h00, 1);
        step();
        bus.shadow_push = 1'b1;
        exp_push("sh_full_cnt", S_CNT, 8'h04, 1);
        exp_push("sh_full_err", S_ERR, 8'h01, 1);
        exp_push("sh_full_p", S_P, 8'hF0, 1);
        step();
        bus.shadow_pop = 1'b1; bus.db_load = 1'b1; bus.db_in = 8'h99;
        exp_push("sh_pop1", S_P, 8'h3C, 1);
        step();
        bus.shadow_pop = 1'b1;
        exp_push("sh_pop2", S_P, 8'h33, 1);
        step();
        bus.shadow_pop = 1'b1;
        exp_push("sh_pop3", S_P, 8'h32, 1);
        step();
        bus.shadow_pop = 1'b1;
        exp_push("sh_pop4", S_P, 8'h31, 1);
        exp_push("sh_empty", S_CNT, 8'h00, 1);
        step();
        bus.shadow_pop = 1'b1;
        exp_push("sh_pop_empty_p", S_P, 8'h31, 1);
        exp_push("sh_pop_empty_cnt", S_CNT, 8'h00, 1);
        exp_push("sh_err_sticky", S_ERR, 8'h01, 1);
        step();
        bus.shadow_push = 1'b1; bus.shadow_pop = 1'b1;
        exp_push("sh_pp_empty_cnt", S_CNT, 8'h01, 1);
        exp_push("sh_pp_empty_p", S_P, 8'h31, 1);
        step();
        bus.db_load = 1'b1; bus.db_in = 8'hF3;
        exp_push("sh_load_f3", S_P, 8'hF3, 1);
        step();
        bus.shadow_push = 1'b1; bus.shadow_pop = 1'b1;
        exp_push("sh_xchg_p", S_P, 8'h31, 1);
        exp_push("sh_xchg_cnt", S_CNT, 8'h01, 1);
        step();
        bus.shadow_pop = 1'b1;
        exp_push("sh_xchg_top", S_P, 8'hF3, 1);
        exp_push("sh_final_cnt", S_CNT, 8'h00, 1);
`else
        step();
        bus.shadow_push = 1'b1; bus.shadow_pop = 1'b1;
        exp_push("noshadow_cnt", S_CNT, 8'h00, 1);
        exp_push("noshadow_err", S_ERR, 8'h00, 1);
        exp_push("noshadow_p", S_P, 8'h34, 1);
        step();
        bus.shadow_pop = 1'b1;
        exp_push("noshadow_pop_p", S_P, 8'h34, 1);
`endif

        repeat (4) step();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        n_checks++;
        if (ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_ack: %0d acks outstanding, expected 0", ack_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
